ycbcr_to_rgb: RTL and testbench

- Inverse colour conversion for the decode/preview path. Accepts packed level-shifted YCbCr samples in the same 36-bit format the encoder front end produces. Returns 8-bit RGB per pixel.
- Fixed-point 3-stage pipeline with valid/ready flow control. Sits between the IDCT/upsampler output and the pixel sink.

---
 rtl/ycc_pkg.sv | 39 +++
 rtl/ycc_round_clamp.sv | 32 +++
 rtl/ycbcr_to_rgb.sv | 108 ++++++++++
 tb/tb_ycbcr_to_rgb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycc_pkg.sv
// Shared constants and types for the YCbCr->RGB decode path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ycc_pkg;

    localparam int FRAC_BITS_DEF = 14;
    localparam int YCC_W         = 12;
    localparam int LEVEL_SHIFT   = 128;

    // Packed sample layout: {y[35:24], cb[23:12], cr[11:0]}
    localparam int Y_LSB  = 2 * YCC_W;
    localparam int CB_LSB = YCC_W;
    localparam int CR_LSB = 0;
    localparam int PACK_W = 3 * YCC_W;

    typedef struct packed {
        logic signed [YCC_W-1:0] y;
        logic signed [YCC_W-1:0] cb;
        logic signed [YCC_W-1:0] cr;
    } ycc_t;

    // Coefficients in parts-per-million, scaled to FRAC_BITS with round-to-nearest.
    // Red/Cr uses 1.40204 so that F=14 yields 22971, the value the encoder-side
    // tables were built with (plain 1.402 would round to 22970).
    localparam longint RCR_PPM = 64'sd1402040;
    localparam longint GCB_PPM = 64'sd344136;
    localparam longint GCR_PPM = 64'sd714136;
    localparam longint BCB_PPM = 64'sd1772000;

    function automatic int coef(input longint ppm, input int frac);
        return int'((ppm * (longint'(1) << frac) + 64'sd500000) / 64'sd1000000);
    endfunction

    localparam int C_RCR = coef(RCR_PPM, FRAC_BITS_DEF);
    localparam int C_GCB = coef(GCB_PPM, FRAC_BITS_DEF);
    localparam int C_GCR = coef(GCR_PPM, FRAC_BITS_DEF);
    localparam int C_BCB = coef(BCB_PPM, FRAC_BITS_DEF);

endpackage

// File: rtl/ycc_round_clamp.sv
// Round-half-up, drop FRAC_BITS, clamp to 0..255 and flag clamping.
// Latency: combinational.
// Backpressure: none (pure function of acc).
// Ports: acc (signed fixed-point channel sum) -> pix (8-bit unsigned), sat (clamped).
module ycc_round_clamp
    import ycc_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ACC_W     = 32
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [7:0]       pix,
    output logic                    sat
);

    logic signed [ACC_W-1:0] rounded;

    always_comb begin
        rounded = (acc + (ACC_W'(1) <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
        pix     = 8'd0;
        sat     = 1'b0;
        if (rounded[ACC_W-1]) begin
            sat = 1'b1;
        end else if (rounded > ACC_W'(255)) begin
            pix = 8'hff;
            sat = 1'b1;
        end else begin
            pix = rounded[7:0];
        end
    end

endmodule

// File: rtl/ycbcr_to_rgb.sv
// Level-shifted YCbCr (3x12-bit signed) to 8-bit RGB with per-channel clamp flags.
// Latency: 3 cycles, 1 pixel/cycle; S1 input reg, S2 base+products, S3 round/clamp.
// Backpressure: global stall, en = !out_valid | out_ready; in_ready = en.
// Ports: in_valid/in_ready/in_ycc upstream; out_valid/out_ready/r/g/b/out_sat downstream.
module ycbcr_to_rgb
    import ycc_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ACC_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PACK_W-1:0] in_ycc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic [2:0]        out_sat
);

    localparam int K_RCR = coef(RCR_PPM, FRAC_BITS);
    localparam int K_GCB = coef(GCB_PPM, FRAC_BITS);
    localparam int K_GCR = coef(GCR_PPM, FRAC_BITS);
    localparam int K_BCB = coef(BCB_PPM, FRAC_BITS);

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [YCC_W-1:0] v);
        return {{(ACC_W - YCC_W){v[YCC_W-1]}}, v};
    endfunction

    logic en;

    // S1
    logic s1_vld;
    ycc_t s1_ycc;

    // S2
    logic                    s2_vld;
    logic signed [ACC_W-1:0] s2_base;
    logic signed [ACC_W-1:0] s2_rcr;
    logic signed [ACC_W-1:0] s2_gcb;
    logic signed [ACC_W-1:0] s2_gcr;
    logic signed [ACC_W-1:0] s2_bcb;

    logic signed [ACC_W-1:0] base_n, rcr_n, gcb_n, gcr_n, bcb_n;
    logic signed [ACC_W-1:0] r_acc, g_acc, b_acc;
    logic [7:0]              r_n, g_n, b_n;
    logic                    r_sat, g_sat, b_sat;

    // One stall signal for every stage: the pipe only moves when the output
    // register is empty or being drained, so nothing can be overwritten.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        base_n = (sx(s1_ycc.y) + ACC_W'(LEVEL_SHIFT)) <<< FRAC_BITS;
        rcr_n  = sx(s1_ycc.cr) * ACC_W'(K_RCR);
        gcb_n  = sx(s1_ycc.cb) * ACC_W'(K_GCB);
        gcr_n  = sx(s1_ycc.cr) * ACC_W'(K_GCR);
        bcb_n  = sx(s1_ycc.cb) * ACC_W'(K_BCB);
    end

    always_comb begin
        r_acc = s2_base + s2_rcr;
        g_acc = s2_base - s2_gcb - s2_gcr;
        b_acc = s2_base + s2_bcb;
    end

    ycc_round_clamp #(.FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_rc_r (.acc(r_acc), .pix(r_n), .sat(r_sat));
    ycc_round_clamp #(.FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_rc_g (.acc(g_acc), .pix(g_n), .sat(g_sat));
    ycc_round_clamp #(.FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_rc_b (.acc(b_acc), .pix(b_n), .sat(b_sat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_ycc    <= '0;
            s2_vld    <= 1'b0;
            s2_base   <= '0;
            s2_rcr    <= '0;
            s2_gcb    <= '0;
            s2_gcr    <= '0;
            s2_bcb    <= '0;
            out_valid <= 1'b0;
            r         <= 8'd0;
            g         <= 8'd0;
            b         <= 8'd0;
            out_sat   <= 3'b000;
        end else if (en) begin
            // Bubbles advance as valid=0 slots; data regs load unconditionally.
            s1_vld    <= in_valid;
            s1_ycc    <= in_ycc;
            s2_vld    <= s1_vld;
            s2_base   <= base_n;
            s2_rcr    <= rcr_n;
            s2_gcb    <= gcb_n;
            s2_gcr    <= gcr_n;
            s2_bcb    <= bcb_n;
            out_valid <= s2_vld;
            r         <= r_n;
            g         <= g_n;
            b         <= b_n;
            out_sat   <= {r_sat, g_sat, b_sat};
        end
    end

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Directed + random bench for ycbcr_to_rgb with an expected-result queue.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected pixels are pushed on acceptance and popped when the DUT hands a pixel downstream.
module tb_ycbcr_to_rgb;

    typedef struct {
        int r;
        int g;
        int b;
        int sat;
        int fr;
        int fg;
        int fb;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_ycc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [2:0]  out_sat;

    int   total;
    int   bad;
    exp_t q[$];

    bit         acc;
    int         sent;
    int         guard;
    int         ry, rcb, rcr;
    logic [7:0] hr, hg, hb;
    logic [2:0] hs;
    int         bp_y[8];
    int         bp_cb[8];
    int         bp_cr[8];

    ycbcr_to_rgb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ycc    (in_ycc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .g         (g),
        .b         (b),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] pk(input int y, input int cb, input int cr);
        return {12'(y), 12'(cb), 12'(cr)};
    endfunction

    function automatic int clip(input longint t);
        if (t < 0) return 0;
        if (t > 255) return 255;
        return int'(t);
    endfunction

    function automatic int oor(input longint t);
        return (t < 0 || t > 255) ? 1 : 0;
    endfunction

    function automatic exp_t mk(input int rr, input int gg, input int bb, input int ss);
        exp_t e;
        e.r = rr; e.g = gg; e.b = bb; e.sat = ss;
        e.fr = rr; e.fg = gg; e.fb = bb;
        return e;
    endfunction

    // Fixed-point model (F=14) plus a floating-point reference for tolerance checks.
    function automatic exp_t model(input int y, input int cb, input int cr);
        exp_t   e;
        longint base, ar, ag, ab, tr, tg, tb;
        real    yr;
        base = longint'(y + 128) * 64'sd16384;
        ar   = base + longint'(cr) * 64'sd22971;
        ag   = base - longint'(cb) * 64'sd5638 - longint'(cr) * 64'sd11700;
        ab   = base + longint'(cb) * 64'sd29032;
        tr   = (ar + 64'sd8192) >>> 14;
        tg   = (ag + 64'sd8192) >>> 14;
        tb   = (ab + 64'sd8192) >>> 14;
        e.r   = clip(tr);
        e.g   = clip(tg);
        e.b   = clip(tb);
        e.sat = oor(tr) * 4 + oor(tg) * 2 + oor(tb);
        yr    = real'(y + 128);
        e.fr  = clip(longint'($floor(yr + 1.402 * cr + 0.5)));
        e.fg  = clip(longint'($floor(yr - 0.344136 * cb - 0.714136 * cr + 0.5)));
        e.fb  = clip(longint'($floor(yr + 1.772 * cb + 0.5)));
        return e;
    endfunction

    task automatic step(input logic v, input logic [35:0] d, input logic ordy,
                        input exp_t e, output bit accepted);
        exp_t x;
        int   dr, dg, db;
        in_valid  = v;
        in_ycc    = d;
        out_ready = ordy;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            check("out_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                x = q.pop_front();
                check("pix_r", r, x.r);
                check("pix_g", g, x.g);
                check("pix_b", b, x.b);
                check("pix_sat", out_sat, x.sat);
                dr = int'(r) - x.fr;
                dg = int'(g) - x.fg;
                db = int'(b) - x.fb;
                check("float_r", (dr <= 1 && dr >= -1), 1);
                check("float_g", (dg <= 1 && dg >= -1), 1);
                check("float_b", (db <= 1 && db >= -1), 1);
            end
        end
        if (accepted) q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 36'd0, 1'b1, mk(0, 0, 0, 0), a);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ycc    = 36'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_rgb_sat", {r, g, b, out_sat}, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Mid-grey and the 3-cycle latency.
        step(1'b1, pk(0, 0, 0), 1'b1, mk(128, 128, 128, 0), acc);
        check("t1_accept", acc, 1);
        step(1'b0, 36'd0, 1'b1, mk(0, 0, 0, 0), acc);
        check("t1_lat2", out_valid, 0);
        step(1'b0, 36'd0, 1'b1, mk(0, 0, 0, 0), acc);
        check("t1_lat3", out_valid, 1);
        idle(2);

        // White, black, a mixed colour, then both saturation cases, back to back.
        step(1'b1, pk(127, 0, 0), 1'b1, mk(255, 255, 255, 0), acc);
        step(1'b1, pk(-128, 0, 0), 1'b1, mk(0, 0, 0, 0), acc);
        step(1'b1, pk(-28, 20, -30), 1'b1, mk(58, 115, 135, 0), acc);
        step(1'b1, pk(0, 0, 511), 1'b1, mk(255, 0, 128, 6), acc);
        step(1'b1, pk(0, -511, 0), 1'b1, mk(128, 255, 0, 3), acc);
        idle(5);
        check("t3_drained", q.size(), 0);

        // Backpressure: 8 samples, output stalled 5 cycles once it appears.
        for (int i = 0; i < 8; i++) begin
            bp_y[i]  = -100 + 25 * i;
            bp_cb[i] = 40 * i - 150;
            bp_cr[i] = 170 - 45 * i;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pk(bp_y[i], bp_cb[i], bp_cr[i]), 1'b1, model(bp_y[i], bp_cb[i], bp_cr[i]), acc);
            check("bp_accept", acc, 1);
        end
        check("bp_out_valid", out_valid, 1);
        hr = r; hg = g; hb = b; hs = out_sat;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, pk(bp_y[3], bp_cb[3], bp_cr[3]), 1'b0, model(bp_y[3], bp_cb[3], bp_cr[3]), acc);
            check("bp_stall_accept", acc, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold", {out_valid, r, g, b, out_sat}, {1'b1, hr, hg, hb, hs});
        end
        for (int i = 3; i < 8; i++) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 20) begin
                step(1'b1, pk(bp_y[i], bp_cb[i], bp_cr[i]), 1'b1, model(bp_y[i], bp_cb[i], bp_cr[i]), acc);
                guard++;
            end
            check("bp_release_accept", acc, 1);
        end
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        check("bp_drained", q.size(), 0);

        // Random valid/ready traffic over the full 12-bit input range.
        sent  = 0;
        guard = 0;
        ry    = int'($urandom_range(0, 4095)) - 2048;
        rcb   = int'($urandom_range(0, 4095)) - 2048;
        rcr   = int'($urandom_range(0, 4095)) - 2048;
        while (sent < 1000 && guard < 20000) begin
            step(($urandom_range(0, 3) != 0), pk(ry, rcb, rcr), ($urandom_range(0, 3) != 0),
                 model(ry, rcb, rcr), acc);
            if (acc) begin
                sent++;
                ry  = int'($urandom_range(0, 4095)) - 2048;
                rcb = int'($urandom_range(0, 4095)) - 2048;
                rcr = int'($urandom_range(0, 4095)) - 2048;
            end
            guard++;
        end
        check("rand_sent", sent, 1000);
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        check("rand_drained", q.size(), 0);

        // Asynchronous reset with three samples in flight.
        step(1'b1, pk(10, 5, 5), 1'b1, model(10, 5, 5), acc);
        step(1'b1, pk(20, -5, 7), 1'b1, model(20, -5, 7), acc);
        step(1'b1, pk(30, 9, -9), 1'b1, model(30, 9, -9), acc);
        check("rs_pre_valid", out_valid, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async_valid", out_valid, 0);
        check("rs_async_rgb", {r, g, b, out_sat}, 0);
        check("rs_async_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        step(1'b1, pk(-28, 20, -30), 1'b1, mk(58, 115, 135, 0), acc);
        check("rs_accept", acc, 1);
        step(1'b0, 36'd0, 1'b1, mk(0, 0, 0, 0), acc);
        check("rs_lat2", out_valid, 0);
        step(1'b0, 36'd0, 1'b1, mk(0, 0, 0, 0), acc);
        check("rs_lat3", out_valid, 1);
        idle(3);
        check("rs_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
